// File: rtl/udp_rx_word_packer_if.sv
// udp_rx_word_packer_if
//   Upstream UDP receive stream: a header phase that carries the destination
//   port, followed by a byte-wide payload phase with a last marker.
//   master : the UDP receive engine (drives header and payload)
//   slave  : the consumer of the stream (drives the two ready signals)
//
//   udp_rx_hdr_valid  header present
//   udp_rx_hdr_ready  header accepted
//   udp_rx_dest_port  destination port, qualified by udp_rx_hdr_valid
//   udp_rx_valid      payload byte valid
//   udp_rx_ready      payload byte accepted
//   udp_rx_last       final payload byte of the datagram
//   udp_rx_data       payload byte
interface udp_rx_word_packer_if;
   logic        udp_rx_hdr_valid;
   logic        udp_rx_hdr_ready;
   logic [15:0] udp_rx_dest_port;
   logic        udp_rx_valid;
   logic        udp_rx_ready;
   logic        udp_rx_last;
   logic [7:0]  udp_rx_data;

   modport master (
      output udp_rx_hdr_valid,
      output udp_rx_dest_port,
      output udp_rx_valid,
      output udp_rx_last,
      output udp_rx_data,
      input  udp_rx_hdr_ready,
      input  udp_rx_ready
   );

   modport slave (
      input  udp_rx_hdr_valid,
      input  udp_rx_dest_port,
      input  udp_rx_valid,
      input  udp_rx_last,
      input  udp_rx_data,
      output udp_rx_hdr_ready,
      output udp_rx_ready
   );
endinterface

// File: rtl/udp_rx_word_packer.sv
// udp_rx_word_packer
//   Accepts UDP datagrams addressed to LISTEN_PORT, packs payload byte pairs
//   into 16-bit words {first byte, second byte} and queues them in a small
//   first-word-fall-through FIFO. Datagrams for other ports are consumed and
//   counted as drops.
//
//   Optional feature macro: UDP_RX_ODD_PAD_EN
//     defined   : a trailing odd byte is padded with 8'h00 and pushed
//     undefined : a trailing odd byte is discarded and counted as a drop
//
//   Parameters
//     LISTEN_PORT  accepted UDP destination port
//     FIFO_DEPTH   output FIFO depth, power of two, >= 2
//
//   Ports
//     i_clk       clock, rising edge
//     i_rst       synchronous active-high reset
//     udp_rx      upstream header/payload stream (slave side)
//     o_data      FIFO head word, 16'h0000 while empty
//     o_valid     FIFO not empty
//     i_ready     consumer pops the head word
//     o_drop_cnt  saturating count of dropped datagrams
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   S_IDLE | waiting for a header; only state with udp_rx_hdr_ready=1
//   S_HIGH | waiting for the first byte of a word
//   S_LOW  | waiting for the second byte; stalls while the FIFO is full
//   S_PAD  | pushing {high, 8'h00} for an odd trailing byte (pad build only)
//   S_DROP | consuming a datagram for a foreign port up to its last byte
module udp_rx_word_packer #(
   parameter logic [15:0] LISTEN_PORT = 16'd1234,
   parameter int          FIFO_DEPTH  = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   udp_rx_word_packer_if.slave  udp_rx,
   output logic [15:0]          o_data,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [7:0]           o_drop_cnt
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HIGH,
      S_LOW,
      S_PAD,
      S_DROP
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    high_q, high_d;
   logic [7:0]    drop_cnt_q, drop_cnt_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [15:0]   mem_q [FIFO_DEPTH];
   logic [15:0]   mem_d [FIFO_DEPTH];

   logic          fifo_full;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   logic [15:0]   push_word;
   logic          drop_inc;
   logic          hdr_ready;
   logic          rx_ready;
   logic          rx_accept;

   // Full/empty come from registered occupancy only, so a pop on a full
   // cycle cannot open the input on that same cycle.
   assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
   assign fifo_empty = (count_q == '0);

   assign rx_accept  = udp_rx.udp_rx_valid && rx_ready;

   // ------------------------------------------------------------------
   // Packing FSM
   // ------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      high_d    = high_q;
      hdr_ready = 1'b0;
      rx_ready  = 1'b0;
      push      = 1'b0;
      push_word = {high_q, udp_rx.udp_rx_data};
      drop_inc  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            hdr_ready = 1'b1;
            if (udp_rx.udp_rx_hdr_valid) begin
               if (udp_rx.udp_rx_dest_port == LISTEN_PORT) begin
                  state_d = S_HIGH;
               end else begin
                  state_d = S_DROP;
               end
            end
         end

         // The high byte is only latched, never pushed, so this state does
         // not depend on FIFO space.
         S_HIGH: begin
            rx_ready = 1'b1;
            if (udp_rx.udp_rx_valid) begin
               high_d = udp_rx.udp_rx_data;
               if (!udp_rx.udp_rx_last) begin
                  state_d = S_LOW;
               end else begin
`ifdef UDP_RX_ODD_PAD_EN
                  state_d = S_PAD;
`else
                  drop_inc = 1'b1;
                  state_d  = S_IDLE;
`endif
               end
            end
         end

         S_LOW: begin
            rx_ready = !fifo_full;
            if (rx_accept) begin
               push    = 1'b1;
               state_d = udp_rx.udp_rx_last ? S_IDLE : S_HIGH;
            end
         end

         S_PAD: begin
            push_word = {high_q, 8'h00};
            if (!fifo_full) begin
               push    = 1'b1;
               state_d = S_IDLE;
            end
         end

         S_DROP: begin
            rx_ready = 1'b1;
            if (udp_rx.udp_rx_valid && udp_rx.udp_rx_last) begin
               drop_inc = 1'b1;
               state_d  = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop_inc && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end
   end

   // ------------------------------------------------------------------
   // Output FIFO
   // ------------------------------------------------------------------
   assign pop = !fifo_empty && i_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;

      if (push) begin
         mem_d[wr_ptr_q] = push_word;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end

      unique case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= S_IDLE;
         high_q     <= 8'h00;
         drop_cnt_q <= 8'h00;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         high_q     <= high_d;
         drop_cnt_q <= drop_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // Storage needs no reset: entries are only visible while occupied.
   always_ff @(posedge i_clk) begin
      mem_q <= mem_d;
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign udp_rx.udp_rx_hdr_ready = hdr_ready;
   assign udp_rx.udp_rx_ready     = rx_ready;

   // Mask the head while empty so the output is a clean zero after reset
   // instead of whatever the unreset storage holds.
   assign o_valid    = !fifo_empty;
   assign o_data     = fifo_empty ? 16'h0000 : mem_q[rd_ptr_q];
   assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_udp_rx_word_packer.sv
// tb_udp_rx_word_packer
//   Directed bench for udp_rx_word_packer: a table of datagrams with their
//   expected packed words and drop count, plus sequences for backpressure,
//   full-FIFO pop/push ordering, drop-counter saturation and mid-datagram
//   reset. Expectations follow UDP_RX_ODD_PAD_EN when it is defined.
module tb_udp_rx_word_packer;

   localparam int BUDGET = 500;

   logic        i_clk;
   logic        i_rst;
   logic [15:0] o_data;
   logic        o_valid;
   logic        i_ready;
   logic [7:0]  o_drop_cnt;

   udp_rx_word_packer_if u_if ();

   udp_rx_word_packer #(
      .LISTEN_PORT (16'd1234),
      .FIFO_DEPTH  (4)
   ) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .udp_rx     (u_if.slave),
      .o_data     (o_data),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_drop_cnt (o_drop_cnt)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic [15:0]          port;
      logic [7:0]           len;
      logic [0:9][7:0]      b;
      logic [7:0]           nwords;
      logic [0:4][15:0]     w;
      logic [7:0]           drop_inc;
   } vec_t;

   localparam int NVEC = 6;
   vec_t vecs [NVEC];

   int n_checks;
   int n_errors;
   int exp_drop;
   logic [15:0] got_q [$];
   logic        sender_done;
   logic [0:9][7:0] tmp_b;

   // Record every word the consumer pops; the pop happens at the next edge.
   always @(negedge i_clk) begin
      if (!i_rst && o_valid && i_ready) got_q.push_back(o_data);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_hdr(input logic [15:0] port);
      logic got;
      int   n;
      got = 1'b0;
      n   = 0;
      u_if.udp_rx_hdr_valid = 1'b1;
      u_if.udp_rx_dest_port = port;
      while (!got && n < BUDGET) begin
         @(negedge i_clk);
         got = u_if.udp_rx_hdr_ready;
         @(posedge i_clk);
         #1;
         n++;
      end
      u_if.udp_rx_hdr_valid = 1'b0;
      if (!got) begin
         n_checks++;
         n_errors++;
         $display("FAIL hdr_timeout: got no hdr_ready expected hdr_ready within %0d cycles", BUDGET);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last);
      logic got;
      int   n;
      got = 1'b0;
      n   = 0;
      u_if.udp_rx_valid = 1'b1;
      u_if.udp_rx_data  = b;
      u_if.udp_rx_last  = last;
      while (!got && n < BUDGET) begin
         @(negedge i_clk);
         got = u_if.udp_rx_ready;
         @(posedge i_clk);
         #1;
         n++;
      end
      u_if.udp_rx_valid = 1'b0;
      u_if.udp_rx_last  = 1'b0;
      if (!got) begin
         n_checks++;
         n_errors++;
         $display("FAIL byte_timeout: got no udp_rx_ready expected ready within %0d cycles", BUDGET);
      end
   endtask

   task automatic send_datagram(input logic [15:0] port, input int len, input logic [0:9][7:0] b);
      send_hdr(port);
      for (int i = 0; i < len; i++) send_byte(b[i], i == len - 1);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      exp_drop    = 0;
      sender_done = 1'b0;
      i_rst       = 1'b1;
      i_ready     = 1'b0;
      u_if.udp_rx_hdr_valid = 1'b0;
      u_if.udp_rx_dest_port = 16'h0000;
      u_if.udp_rx_valid     = 1'b0;
      u_if.udp_rx_last      = 1'b0;
      u_if.udp_rx_data      = 8'h00;

      vecs[0] = '{port: 16'd1234, len: 8'd4,
                  b: {8'h12, 8'h34, 8'h56, 8'h78, 48'h0},
                  nwords: 8'd2, w: {16'h1234, 16'h5678, 48'h0}, drop_inc: 8'd0};
      vecs[1] = '{port: 16'd80, len: 8'd3,
                  b: {8'hAA, 8'hBB, 8'hCC, 56'h0},
                  nwords: 8'd0, w: 80'h0, drop_inc: 8'd1};
`ifdef UDP_RX_ODD_PAD_EN
      vecs[2] = '{port: 16'd1234, len: 8'd3,
                  b: {8'hAB, 8'hCD, 8'hEF, 56'h0},
                  nwords: 8'd2, w: {16'hABCD, 16'hEF00, 48'h0}, drop_inc: 8'd0};
      vecs[3] = '{port: 16'd1234, len: 8'd1,
                  b: {8'h5A, 72'h0},
                  nwords: 8'd1, w: {16'h5A00, 64'h0}, drop_inc: 8'd0};
`else
      vecs[2] = '{port: 16'd1234, len: 8'd3,
                  b: {8'hAB, 8'hCD, 8'hEF, 56'h0},
                  nwords: 8'd1, w: {16'hABCD, 64'h0}, drop_inc: 8'd1};
      vecs[3] = '{port: 16'd1234, len: 8'd1,
                  b: {8'h5A, 72'h0},
                  nwords: 8'd0, w: 80'h0, drop_inc: 8'd1};
`endif
      vecs[4] = '{port: 16'd1235, len: 8'd2,
                  b: {8'h01, 8'h02, 64'h0},
                  nwords: 8'd0, w: 80'h0, drop_inc: 8'd1};
      vecs[5] = '{port: 16'd1234, len: 8'd6,
                  b: {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 32'h0},
                  nwords: 8'd3, w: {16'h0102, 16'h0304, 16'h0506, 32'h0}, drop_inc: 8'd0};

      // Reset state
      repeat (3) @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      @(negedge i_clk);
      chk("rst_o_valid",   32'(o_valid), 32'd0);
      chk("rst_rx_ready",  32'(u_if.udp_rx_ready), 32'd0);
      chk("rst_hdr_ready", 32'(u_if.udp_rx_hdr_ready), 32'd1);
      chk("rst_o_data",    32'(o_data), 32'h0);
      chk("rst_drop_cnt",  32'(o_drop_cnt), 32'd0);
      @(posedge i_clk);
      #1;

      // Table-driven datagrams, consumer always ready
      i_ready = 1'b1;
      for (int v = 0; v < NVEC; v++) begin
         got_q.delete();
         send_datagram(vecs[v].port, int'(vecs[v].len), vecs[v].b);
         idle_cycles(6);
         exp_drop = exp_drop + int'(vecs[v].drop_inc);
         chk($sformatf("vec%0d_nwords", v), 32'(got_q.size()), 32'(vecs[v].nwords));
         for (int k = 0; k < int'(vecs[v].nwords); k++) begin
            if (k < got_q.size())
               chk($sformatf("vec%0d_word%0d", v, k), 32'(got_q[k]), 32'(vecs[v].w[k]));
         end
         chk($sformatf("vec%0d_drop_cnt", v), 32'(o_drop_cnt), 32'(exp_drop));
      end

      // Backpressure: 10-byte datagram with consumer stalled
      i_ready = 1'b0;
      got_q.delete();
      sender_done = 1'b0;
      tmp_b = {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hA9};
      fork
         begin
            send_datagram(16'd1234, 10, tmp_b);
            sender_done = 1'b1;
         end
      join_none
      idle_cycles(40);
      @(negedge i_clk);
      chk("bp_full_o_valid",   32'(o_valid), 32'd1);
      chk("bp_full_head",      32'(o_data), 32'hA0A1);
      chk("bp_full_rx_ready",  32'(u_if.udp_rx_ready), 32'd0);
      chk("bp_full_hdr_ready", 32'(u_if.udp_rx_hdr_ready), 32'd0);
      chk("bp_full_no_pops",   32'(got_q.size()), 32'd0);
      @(posedge i_clk);
      #1;
      i_ready = 1'b1;
      // Pop happens at the coming edge; the pending byte must still wait.
      @(negedge i_clk);
      chk("pop_cycle_rx_ready", 32'(u_if.udp_rx_ready), 32'd0);
      chk("pop_cycle_head",     32'(o_data), 32'hA0A1);
      @(posedge i_clk);
      #1;
      @(negedge i_clk);
      chk("after_pop_rx_ready", 32'(u_if.udp_rx_ready), 32'd1);
      chk("after_pop_head",     32'(o_data), 32'hA2A3);
      for (int n = 0; n < BUDGET && !sender_done; n++) @(posedge i_clk);
      #1;
      chk("bp_sender_done", 32'(sender_done), 32'd1);
      idle_cycles(8);
      chk("bp_nwords", 32'(got_q.size()), 32'd5);
      for (int k = 0; k < 5; k++) begin
         if (k < got_q.size())
            chk($sformatf("bp_word%0d", k), 32'(got_q[k]), 32'(16'hA0A1 + 16'h0202 * k));
      end
      chk("bp_drop_cnt", 32'(o_drop_cnt), 32'(exp_drop));

      // Drop counter saturation
      tmp_b = {8'h11, 8'h22, 8'h33, 56'h0};
      for (int d = 0; d < 300; d++) send_datagram(16'd80, 3, tmp_b);
      idle_cycles(2);
      exp_drop = (exp_drop + 300 > 255) ? 255 : exp_drop + 300;
      chk("drop_saturated", 32'(o_drop_cnt), 32'(exp_drop));
      chk("drop_no_words",  32'(o_valid), 32'd0);

      // Reset mid-datagram with one word queued
      i_ready = 1'b0;
      got_q.delete();
      send_hdr(16'd1234);
      send_byte(8'h31, 1'b0);
      send_byte(8'h32, 1'b0);
      @(negedge i_clk);
      chk("pre_rst_o_valid", 32'(o_valid), 32'd1);
      chk("pre_rst_head",    32'(o_data), 32'h3132);
      @(posedge i_clk);
      #1;
      i_rst = 1'b1;
      u_if.udp_rx_valid = 1'b1;
      u_if.udp_rx_data  = 8'h33;
      u_if.udp_rx_last  = 1'b0;
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      @(negedge i_clk);
      chk("mid_rst_o_valid",   32'(o_valid), 32'd0);
      chk("mid_rst_o_data",    32'(o_data), 32'h0);
      chk("mid_rst_rx_ready",  32'(u_if.udp_rx_ready), 32'd0);
      chk("mid_rst_hdr_ready", 32'(u_if.udp_rx_hdr_ready), 32'd1);
      chk("mid_rst_drop_cnt",  32'(o_drop_cnt), 32'd0);
      @(posedge i_clk);
      #1;
      u_if.udp_rx_valid = 1'b0;
      exp_drop = 0;
      i_ready  = 1'b1;
      tmp_b = {8'h11, 8'h22, 64'h0};
      send_datagram(16'd1234, 2, tmp_b);
      idle_cycles(6);
      chk("post_rst_nwords", 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0) chk("post_rst_word", 32'(got_q[0]), 32'h1122);
      chk("post_rst_drop_cnt", 32'(o_drop_cnt), 32'(exp_drop));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global guard so a stuck run still ends with a summary line.
   initial begin
      #2000000;
      n_errors++;
      $display("FAIL global_timeout: got still running expected finish");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/udp_rx_word_packer.md
UDP_RX_WORD_PACKER -- requirements
Module: udp_rx_word_packer

Interface
REQ-001 SHALL have parameter LISTEN_PORT, default 16'd1234: UDP destination port accepted; all other ports are dropped.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: output word FIFO depth, a power of two, at least 2.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 i_clk  in  1  clock; all logic on the rising edge.
REQ-005 i_rst  in  1  synchronous active-high reset.
REQ-006 udp_rx_hdr_valid  in  1  UDP header present.
REQ-007 udp_rx_hdr_ready  out  1  header accepted.
REQ-008 udp_rx_dest_port  in  16  destination port, qualified by udp_rx_hdr_valid.
REQ-009 udp_rx_valid  in  1  payload byte valid.
REQ-010 udp_rx_ready  out  1  payload byte accepted.
REQ-011 udp_rx_last  in  1  final payload byte of the datagram.
REQ-012 udp_rx_data  in  8  payload byte.
REQ-013 o_data  out  16  FIFO head word, {first byte, second byte}.
REQ-014 o_valid  out  1  FIFO not empty.
REQ-015 i_ready  in  1  consumer pops the head word.
REQ-016 o_drop_cnt  out  8  count of dropped datagrams, saturating.

Function
REQ-017 SHALL implement states S_IDLE, S_HIGH, S_LOW, S_PAD and S_DROP.
REQ-018 S_IDLE: udp_rx_hdr_ready=1 and udp_rx_ready=0; on udp_rx_hdr_valid, go to S_HIGH if udp_rx_dest_port==LISTEN_PORT, else go to S_DROP.
REQ-019 S_HIGH: udp_rx_ready=1; an accepted byte is latched as the high byte; with udp_rx_last=0 go to S_LOW; with udp_rx_last=1, handle per REQ-030/031.
REQ-020 S_LOW: udp_rx_ready=!fifo_full; on accept, push {high, udp_rx_data}; with udp_rx_last=1 go to S_IDLE, else go to S_HIGH.
REQ-021 S_DROP: udp_rx_ready=1; consume bytes until an accepted byte has udp_rx_last=1, then go to S_IDLE and increment o_drop_cnt, saturating at 255.
REQ-022 udp_rx_hdr_ready SHALL be 0 in every state except S_IDLE.
REQ-023 FIFO SHALL be first-word-fall-through: o_valid=!empty; o_data=head word; pop when o_valid&&i_ready.
REQ-024 Latency: a word pushed at edge N SHALL appear on o_data with o_valid=1 after edge N; the FIFO has no input-to-output bypass.
REQ-025 Push and pop in the same cycle SHALL both take effect; occupancy is unchanged.
REQ-026 Full: no push occurs; udp_rx_ready is held low in S_LOW/S_PAD until a pop frees an entry; a pop on the full cycle SHALL NOT admit a push on that same cycle.
REQ-027 Empty: i_ready SHALL be ignored; no pointer moves.
REQ-028 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; an extra occupancy bit distinguishes full from empty.
REQ-029 Zero-length datagram, i.e. header with no payload: not possible upstream; no special handling is required.

Configuration
REQ-030 With UDP_RX_ODD_PAD_EN defined: a last byte in S_HIGH SHALL go to S_PAD; S_PAD pushes {high, 8'h00} when !fifo_full, then goes to S_IDLE.
REQ-031 Without UDP_RX_ODD_PAD_EN: a last byte in S_HIGH SHALL be discarded; o_drop_cnt increments (saturating) and the state goes to S_IDLE; S_PAD is unreachable.

Reset
REQ-032 While i_rst=1 at a clock edge, the next state SHALL be: S_IDLE, FIFO empty, pointers 0, latched high byte 0, o_drop_cnt=0.
REQ-033 After reset: o_valid=0, udp_rx_ready=0, udp_rx_hdr_ready=1, o_data=16'h0000.
REQ-034 Reset mid-datagram SHALL discard any partial word and all FIFO content; remaining payload bytes stall because udp_rx_ready=0 in S_IDLE.

Verification
REQ-035 Port 1234, payload 12 34 56 78, i_ready=1 -> o_data 16'h1234 then 16'h5678, o_drop_cnt=0.
REQ-036 Port 80, 3-byte payload -> no o_valid, all bytes accepted, o_drop_cnt=1; 300 such datagrams -> o_drop_cnt=255.
REQ-037 i_ready=0, 10-byte datagram, FIFO_DEPTH=4 -> 4 words held, udp_rx_ready=0 in S_LOW; then i_ready=1 -> all 5 words in order.
REQ-038 Payload AB CD EF -> with macro: 16'hABCD, 16'hEF00; without macro: 16'hABCD only, o_drop_cnt=1.
REQ-039 Reset asserted after byte 2 of 6 with 1 word queued -> o_valid=0 next cycle; next valid datagram 11 22 -> 16'h1122 only.
REQ-040 Full FIFO, i_ready=1 and a byte pending in S_LOW on the same cycle -> pop occurs, push deferred exactly one cycle, no word lost.
